// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - bf16 format types, constants and classification helpers
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam int          BF16_BIAS = 127;

  function automatic logic bf16_is_nan(input bf16_t x);
    return (x.exp == 8'hFF) && (x.frac != 7'd0);
  endfunction

  function automatic logic bf16_is_inf(input bf16_t x);
    return (x.exp == 8'hFF) && (x.frac == 7'd0);
  endfunction

  // Subnormals carry no weight here: a zero exponent field means zero.
  function automatic logic bf16_is_zero(input bf16_t x);
    return x.exp == 8'h00;
  endfunction

endpackage

// File: rtl/bf16_rne_round.sv
// rtl/bf16_rne_round.sv - round-to-nearest-even and range clamp to a bf16 result
module bf16_rne_round
  import bf16_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [7:0]        sig_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output bf16_t             result_o
);

  logic              round_up;
  logic [8:0]        sig_rnd;
  logic signed [9:0] exp_rnd;
  logic [6:0]        frac_rnd;

  // Round ties to even, renormalise on carry-out, then clamp to Inf or signed zero
  always_comb begin
    round_up = guard_i & (sticky_i | sig_i[0]);
    sig_rnd  = {1'b0, sig_i} + {8'd0, round_up};
    if (sig_rnd[8]) begin
      exp_rnd  = exp_i + 10'sd1;
      frac_rnd = sig_rnd[7:1];
    end else begin
      exp_rnd  = exp_i;
      frac_rnd = sig_rnd[6:0];
    end
    if (exp_rnd >= 10'sd255) begin
      result_o = {sign_i, BF16_PINF[14:0]};
    end else if (exp_rnd <= 10'sd0) begin
      result_o = {sign_i, 15'd0};
    end else begin
      result_o = {sign_i, exp_rnd[7:0], frac_rnd};
    end
  end

endmodule

// File: rtl/vexp_arith_bf16.sv
// rtl/vexp_arith_bf16.sv - pipelined bf16 multiply and add/sub responder lanes
module vexp_arith_bf16
  import bf16_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int ADD_STAGES = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        mul_valid_in,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  input  logic        add_valid_in,
  input  logic [15:0] add_a,
  input  logic [15:0] add_b,
  input  logic        sub,
  output logic        mul_valid_out,
  output logic [15:0] mul_out,
  output logic        add_valid_out,
  output logic [15:0] add_out
);

  // ---------------- multiply lane ----------------
  bf16_t             ma, mb;
  logic              m_sign;
  logic [15:0]       m_prod;
  logic              m_norm;
  logic signed [9:0] m_exp;
  logic [7:0]        m_sig;
  logic              m_guard, m_sticky;
  bf16_t             m_rnd;
  logic [15:0]       mul_res_d;

  assign ma = mul_a;
  assign mb = mul_b;

  // Significand product with one-step normalisation and guard/sticky extraction
  always_comb begin
    m_sign = ma.sign ^ mb.sign;
    m_prod = 16'({1'b1, ma.frac}) * 16'({1'b1, mb.frac});
    m_norm = m_prod[15];
    m_exp  = $signed({2'b00, ma.exp}) + $signed({2'b00, mb.exp})
           - $signed(10'(BF16_BIAS)) + (m_norm ? 10'sd1 : 10'sd0);
    if (m_norm) begin
      m_sig    = m_prod[15:8];
      m_guard  = m_prod[7];
      m_sticky = |m_prod[6:0];
    end else begin
      m_sig    = m_prod[14:7];
      m_guard  = m_prod[6];
      m_sticky = |m_prod[5:0];
    end
  end

  bf16_rne_round u_mul_round (
    .sign_i   (m_sign),
    .exp_i    (m_exp),
    .sig_i    (m_sig),
    .guard_i  (m_guard),
    .sticky_i (m_sticky),
    .result_o (m_rnd)
  );

  // Special operands override the rounded datapath result
  always_comb begin
    if (bf16_is_nan(ma) || bf16_is_nan(mb) ||
        (bf16_is_inf(ma) && bf16_is_zero(mb)) ||
        (bf16_is_inf(mb) && bf16_is_zero(ma))) begin
      mul_res_d = BF16_QNAN;
    end else if (bf16_is_inf(ma) || bf16_is_inf(mb)) begin
      mul_res_d = {m_sign, BF16_PINF[14:0]};
    end else if (bf16_is_zero(ma) || bf16_is_zero(mb)) begin
      mul_res_d = {m_sign, 15'd0};
    end else begin
      mul_res_d = m_rnd;
    end
  end

  // ---------------- add lane ----------------
  bf16_t             aa, ab;
  logic              a_sb, a_swap, a_eff_sub, a_sign;
  bf16_t             a_big, a_small;
  logic [7:0]        a_diff;
  logic [10:0]       a_ml, a_ms, a_al, a_shl;
  logic [20:0]       a_ext;
  logic [11:0]       a_sum;
  logic [3:0]        a_lzc;
  logic signed [9:0] a_exp;
  logic [7:0]        a_sig;
  logic              a_guard, a_sticky;
  bf16_t             a_rnd;
  logic [15:0]       add_res_d;

  assign aa = add_a;
  assign ab = add_b;

  // Order by magnitude, align with guard/round/sticky, add or subtract, normalise
  always_comb begin
    a_sb      = ab.sign ^ sub;
    a_swap    = {ab.exp, ab.frac} > {aa.exp, aa.frac};
    a_big     = a_swap ? {a_sb, ab.exp, ab.frac} : aa;
    a_small   = a_swap ? aa : {a_sb, ab.exp, ab.frac};
    a_eff_sub = a_big.sign ^ a_small.sign;
    a_sign    = a_big.sign;
    a_diff    = a_big.exp - a_small.exp;
    a_ml      = {1'b1, a_big.frac, 3'b000};
    a_ms      = {1'b1, a_small.frac, 3'b000};
    a_ext     = {a_ms, 10'd0} >> a_diff;
    // Beyond 10 places the smaller operand only contributes to sticky
    if (a_diff >= 8'd10) begin
      a_al = 11'd1;
    end else begin
      a_al = a_ext[20:10] | {10'd0, |a_ext[9:0]};
    end
    a_sum = a_eff_sub ? ({1'b0, a_ml} - {1'b0, a_al}) : ({1'b0, a_ml} + {1'b0, a_al});
    a_lzc = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (a_sum[i]) a_lzc = 4'(10 - i);
    end
    a_shl = a_sum[10:0] << a_lzc;
    if (a_sum[11]) begin
      a_exp    = $signed({2'b00, a_big.exp}) + 10'sd1;
      a_sig    = a_sum[11:4];
      a_guard  = a_sum[3];
      a_sticky = |a_sum[2:0];
    end else begin
      a_exp    = $signed({2'b00, a_big.exp}) - $signed({6'd0, a_lzc});
      a_sig    = a_shl[10:3];
      a_guard  = a_shl[2];
      a_sticky = |a_shl[1:0];
    end
  end

  bf16_rne_round u_add_round (
    .sign_i   (a_sign),
    .exp_i    (a_exp),
    .sig_i    (a_sig),
    .guard_i  (a_guard),
    .sticky_i (a_sticky),
    .result_o (a_rnd)
  );

  // Special operands, zero operands and exact cancellation override the datapath
  always_comb begin
    if (bf16_is_nan(aa) || bf16_is_nan(ab) ||
        (bf16_is_inf(aa) && bf16_is_inf(ab) && (aa.sign != a_sb))) begin
      add_res_d = BF16_QNAN;
    end else if (bf16_is_inf(aa)) begin
      add_res_d = {aa.sign, BF16_PINF[14:0]};
    end else if (bf16_is_inf(ab)) begin
      add_res_d = {a_sb, BF16_PINF[14:0]};
    end else if (bf16_is_zero(aa) && bf16_is_zero(ab)) begin
      add_res_d = {aa.sign & a_sb, 15'd0};
    end else if (bf16_is_zero(aa)) begin
      add_res_d = {a_sb, ab.exp, ab.frac};
    end else if (bf16_is_zero(ab)) begin
      add_res_d = aa;
    end else if (a_sum == 12'd0) begin
      add_res_d = BF16_ZERO;
    end else begin
      add_res_d = a_rnd;
    end
  end

  // ---------------- pipelines ----------------
  logic [MUL_STAGES-1:0] mul_v_q;
  logic [15:0]           mul_res_q [MUL_STAGES];
  logic [ADD_STAGES-1:0] add_v_q;
  logic [15:0]           add_res_q [ADD_STAGES];

  // Multiply: stage 0 captures the result (zero when idle), later stages only delay
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mul_v_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mul_res_q[i] <= BF16_ZERO;
    end else begin
      mul_v_q[0]   <= mul_valid_in;
      mul_res_q[0] <= mul_valid_in ? mul_res_d : BF16_ZERO;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_v_q[i]   <= mul_v_q[i-1];
        mul_res_q[i] <= mul_res_q[i-1];
      end
    end
  end

  // Add: stage 0 captures the result (zero when idle), later stages only delay
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      add_v_q <= '0;
      for (int i = 0; i < ADD_STAGES; i++) add_res_q[i] <= BF16_ZERO;
    end else begin
      add_v_q[0]   <= add_valid_in;
      add_res_q[0] <= add_valid_in ? add_res_d : BF16_ZERO;
      for (int i = 1; i < ADD_STAGES; i++) begin
        add_v_q[i]   <= add_v_q[i-1];
        add_res_q[i] <= add_res_q[i-1];
      end
    end
  end

  assign mul_valid_out = mul_v_q[MUL_STAGES-1];
  assign mul_out       = mul_res_q[MUL_STAGES-1];
  assign add_valid_out = add_v_q[ADD_STAGES-1];
  assign add_out       = add_res_q[ADD_STAGES-1];

endmodule
